aes_rcon_seq: RTL and testbench

Parametrised round-constant and word-schedule sequencer for the AES key expansion, supporting AES-128/192/256. It drives the key-expansion datapath one 32-bit schedule word per `adv`, flagging which words need RotWord+SubWord+Rcon or SubWord only, and supplying the Rcon value. It replaces the fixed 128-bit free-running Rcon generator with a handshaked, key-length-aware sequencer. It can optionally run the schedule in reverse for on-the-fly decryption key generation.

---
 rtl/aes_rcon_seq.sv | 178 +++++++++++++++++
 tb/tb_aes_rcon_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aes_rcon_seq.sv
// AES key-schedule sequencer: steps one 32-bit schedule word per adv and flags
// RotWord/SubWord/Rcon words. Define AES_RCON_REVERSE_EN to build reverse sequencing.
module aes_rcon_seq #(
  parameter int unsigned RCON_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kld,
  input  logic [1:0]        klen,
  input  logic              dir,
  input  logic              adv,
  output logic [RCON_W-1:0] out,
  output logic              rot_sub,
  output logic              sub_only,
  output logic [5:0]        widx,
  output logic              last,
  output logic              busy
);

  logic [5:0] widx_q, widx_d;
  logic [2:0] j_q, j_d;
  logic [7:0] rc_q, rc_d;
  logic [3:0] nk_q, nk_d;
  logic [5:0] nw_q, nw_d;
  logic       busy_q, busy_d;
  logic       last_w;
  logic [7:0] out_byte;

  logic [3:0] ld_nk;
  logic [5:0] ld_nw;

`ifdef AES_RCON_REVERSE_EN
  logic       rev_q, rev_d;
  logic [7:0] ld_rc_rev;
`else
  logic rev_q;
  logic unused_dir;
  assign rev_q      = 1'b0;
  assign unused_dir = dir;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_RCON_REVERSE_EN
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] t;
    t = x ^ 8'h1b;
    return x[0] ? {1'b1, t[7:1]} : {1'b0, x[7:1]};
  endfunction
`endif

  // Key-length decode; code 3 aliases AES-128.
  always_comb begin
    ld_nk = 4'd4;
    ld_nw = 6'd44;
`ifdef AES_RCON_REVERSE_EN
    ld_rc_rev = 8'h36;
`endif
    unique case (klen)
      2'd1: begin
        ld_nk = 4'd6;
        ld_nw = 6'd52;
`ifdef AES_RCON_REVERSE_EN
        ld_rc_rev = 8'h80;
`endif
      end
      2'd2: begin
        ld_nk = 4'd8;
        ld_nw = 6'd60;
`ifdef AES_RCON_REVERSE_EN
        ld_rc_rev = 8'h40;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    last_w = 1'b0;
    if (busy_q) begin
      last_w = rev_q ? (widx_q == {2'b00, nk_q}) : (widx_q == nw_q - 6'd1);
    end
  end

  always_comb begin
    widx_d = widx_q;
    j_d    = j_q;
    rc_d   = rc_q;
    nk_d   = nk_q;
    nw_d   = nw_q;
    busy_d = busy_q;
`ifdef AES_RCON_REVERSE_EN
    rev_d  = rev_q;
`endif
    if (kld) begin
      nk_d   = ld_nk;
      nw_d   = ld_nw;
      busy_d = 1'b1;
      widx_d = {2'b00, ld_nk};
      j_d    = 3'd0;
      rc_d   = 8'h01;
`ifdef AES_RCON_REVERSE_EN
      rev_d  = dir;
      // Nw-1 is 3 mod Nk for every key length, so j starts at 3.
      if (dir) begin
        widx_d = ld_nw - 6'd1;
        j_d    = 3'd3;
        rc_d   = ld_rc_rev;
      end
`endif
    end else if (adv && busy_q) begin
      if (last_w) begin
        busy_d = 1'b0;
`ifdef AES_RCON_REVERSE_EN
      end else if (rev_q) begin
        widx_d = widx_q - 6'd1;
        if (j_q == 3'd0) begin
          j_d  = nk_q[2:0] - 3'd1;
          rc_d = inv_xtime(rc_q);
        end else begin
          j_d = j_q - 3'd1;
        end
`endif
      end else begin
        widx_d = widx_q + 6'd1;
        if ({1'b0, j_q} == nk_q - 4'd1) begin
          j_d  = 3'd0;
          rc_d = xtime(rc_q);
        end else begin
          j_d = j_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q <= 6'd0;
      j_q    <= 3'd0;
      rc_q   <= 8'h01;
      nk_q   <= 4'd4;
      nw_q   <= 6'd44;
      busy_q <= 1'b0;
    end else begin
      widx_q <= widx_d;
      j_q    <= j_d;
      rc_q   <= rc_d;
      nk_q   <= nk_d;
      nw_q   <= nw_d;
      busy_q <= busy_d;
    end
  end

`ifdef AES_RCON_REVERSE_EN
  always_ff @(posedge clk) begin
    if (rst) rev_q <= 1'b0;
    else     rev_q <= rev_d;
  end
`endif

  assign rot_sub  = busy_q && (j_q == 3'd0);
  assign sub_only = busy_q && (nk_q == 4'd8) && (j_q == 3'd4);
  assign widx     = widx_q;
  assign last     = last_w;
  assign busy     = busy_q;
  assign out_byte = rot_sub ? rc_q : 8'h00;

  generate
    if (RCON_W == 8) begin : g_out_byte
      assign out = out_byte;
    end else begin : g_out_word
      assign out = {out_byte, {(RCON_W-8){1'b0}}};
    end
  endgenerate

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Self-checking bench for aes_rcon_seq: directed vector table plus full schedule runs.
module tb_aes_rcon_seq;

  logic        clk;
  logic        rst;
  logic        kld;
  logic [1:0]  klen;
  logic        dir;
  logic        adv;
  logic [31:0] out;
  logic        rot_sub;
  logic        sub_only;
  logic [5:0]  widx;
  logic        last;
  logic        busy;

  int checks;
  int errors;

  logic [7:0] rcon_tab [10];

  aes_rcon_seq #(.RCON_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .klen     (klen),
    .dir      (dir),
    .adv      (adv),
    .out      (out),
    .rot_sub  (rot_sub),
    .sub_only (sub_only),
    .widx     (widx),
    .last     (last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        kld;
    logic [1:0]  klen;
    logic        dir;
    logic        adv;
    logic [5:0]  e_widx;
    logic        e_busy;
    logic        e_rot;
    logic        e_sub;
    logic        e_last;
    logic [31:0] e_out;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] e_widx, input logic e_busy,
                         input logic e_rot, input logic e_sub, input logic e_last,
                         input logic [31:0] e_out);
    chk({tag, ".widx"}, {26'd0, widx}, {26'd0, e_widx});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".rot_sub"}, {31'd0, rot_sub}, {31'd0, e_rot});
    chk({tag, ".sub_only"}, {31'd0, sub_only}, {31'd0, e_sub});
    chk({tag, ".last"}, {31'd0, last}, {31'd0, e_last});
    chk({tag, ".out"}, out, e_out);
  endtask

  // Expected outputs for schedule word w from the standard Rcon table.
  task automatic check_word(input string tag, input int w, input int nk, input int nw,
                            input bit fwd);
    int m;
    int g;
    logic e_rot, e_sub, e_last;
    logic [31:0] e_out;
    m      = w % nk;
    g      = w / nk;
    e_rot  = (m == 0);
    e_sub  = (nk == 8) && (m == 4);
    e_last = fwd ? (w == nw - 1) : (w == nk);
    e_out  = e_rot ? {rcon_tab[g-1], 24'h0} : 32'h0;
    chk_all($sformatf("%s.w%0d", tag, w), w[5:0], 1'b1, e_rot, e_sub, e_last, e_out);
  endtask

  task automatic run_seq(input string tag, input logic [1:0] kl, input logic drv_dir,
                         input bit rev, input int nk, input int nw);
    int w;
    @(negedge clk);
    kld = 1'b1; klen = kl; dir = drv_dir; adv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    kld = 1'b0; adv = 1'b1;
    w = rev ? nw - 1 : nk;
    for (int s = 0; s < nw - nk; s++) begin
      check_word(tag, w, nk, nw, !rev);
      @(posedge clk); #1;
      if (s != nw - nk - 1) w = rev ? w - 1 : w + 1;
    end
    // The adv taken on the last word ends the run; widx holds.
    chk_all({tag, ".end"}, w[5:0], 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    adv = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
    rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
    rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;

    //            rst   kld   klen  dir   adv   widx  busy  rot   sub   last  out
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 6'd4,  1'b1, 1'b1, 1'b0, 1'b0, 32'h01000000};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 6'd6,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 6'd7,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 6'd8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h02000000};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 6'd8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h01000000};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 6'd9,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 6'd4,  1'b1, 1'b1, 1'b0, 1'b0, 32'h01000000};
    vecs[15] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 6'd6,  1'b1, 1'b1, 1'b0, 1'b0, 32'h01000000};

    rst = 1'b1; kld = 1'b0; klen = 2'd0; dir = 1'b0; adv = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; kld = vecs[i].kld; klen = vecs[i].klen;
      dir = vecs[i].dir; adv = vecs[i].adv;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_widx, vecs[i].e_busy, vecs[i].e_rot,
              vecs[i].e_sub, vecs[i].e_last, vecs[i].e_out);
    end
    @(negedge clk);
    rst = 1'b0; kld = 1'b0; adv = 1'b0;

    run_seq("fwd128", 2'd0, 1'b0, 1'b0, 4, 44);
    run_seq("fwd192", 2'd1, 1'b0, 1'b0, 6, 52);
    run_seq("fwd256", 2'd2, 1'b0, 1'b0, 8, 60);

    // Reload mid-sequence at widx=20; the same-cycle adv must be dropped.
    @(negedge clk);
    kld = 1'b1; klen = 2'd2; dir = 1'b0; adv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    kld = 1'b0; adv = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk_all("mid.pre", 6'd20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    kld = 1'b1;
    @(posedge clk); #1;
    chk_all("mid.reload", 6'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h01000000);
    @(negedge clk);
    kld = 1'b0; adv = 1'b0;

`ifdef AES_RCON_REVERSE_EN
    run_seq("rev128", 2'd0, 1'b1, 1'b1, 4, 44);
    run_seq("rev192", 2'd1, 1'b1, 1'b1, 6, 52);
    run_seq("rev256", 2'd2, 1'b1, 1'b1, 8, 60);
`else
    // Without the reverse build, dir is ignored and every load runs forward.
    run_seq("dirign", 2'd0, 1'b1, 1'b0, 4, 44);
`endif

    // Reset mid-sequence.
    @(negedge clk);
    kld = 1'b1; klen = 2'd1; dir = 1'b0;
    @(negedge clk);
    kld = 1'b0; adv = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst.mid", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0; adv = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
